vending_machine_changer: RTL

- Parametrised successor to the single-price coin-sensor vending machine.
- Classifies each coin by the width of its coinSensor pulse and accumulates credit in nickel units.
- Dispenses one item at a configurable price, rejects coins that are malformed or arrive during change return, and returns remaining credit as a nickel pulse train on request.
- Sits between the coin-sensor pad and the dispenser/coin-return solenoid drivers.

---
 rtl/vending_machine_changer.sv | 105 ++++++++++
 1 files changed

// File: rtl/vending_machine_changer.sv
// vending_machine_changer: classifies coins by sensor pulse width, accumulates credit, dispenses at PRICE and returns change
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   coinSensor   high while a coin passes the sensor
//   coinReturn   level request to return the current credit
//   dispense     one-cycle pulse releasing one item
//   coinReject   one-cycle pulse diverting the coin just measured
//   changeNickel one-cycle pulse per nickel returned
//   returning    high while change return is in progress
//   credit       current credit in nickels
module vending_machine_changer #(
    parameter int dimeMin    = 2,
    parameter int dimeMax    = 4,
    parameter int nickelMin  = 6,
    parameter int nickelMax  = 8,
    parameter int quarterMin = 10,
    parameter int quarterMax = 12,
    parameter int CNT_W      = 21,
    parameter int PRICE      = 5,
    parameter int CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coinSensor,
    input  logic                coinReturn,
    output logic                dispense,
    output logic                coinReject,
    output logic                changeNickel,
    output logic                returning,
    output logic [CREDIT_W-1:0] credit
);
    localparam logic [CNT_W-1:0]  D_MIN   = CNT_W'(dimeMin);
    localparam logic [CNT_W-1:0]  D_MAX   = CNT_W'(dimeMax);
    localparam logic [CNT_W-1:0]  N_MIN   = CNT_W'(nickelMin);
    localparam logic [CNT_W-1:0]  N_MAX   = CNT_W'(nickelMax);
    localparam logic [CNT_W-1:0]  Q_MIN   = CNT_W'(quarterMin);
    localparam logic [CNT_W-1:0]  Q_MAX   = CNT_W'(quarterMax);
    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

    typedef enum logic [1:0] {IDLE, RET_HI, RET_LO} state_t;

    state_t              state, state_n;
    logic                sensQ, retQ, sensPrev;
    logic [CNT_W-1:0]    cnt;
    logic                coin_ev, valid, accept;
    logic [2:0]          value;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] credit_n;
    logic                dispense_n, reject_n;

    // Falling edge of the registered sensor marks the end of a coin; cnt still holds its width.
    assign coin_ev = sensPrev && !sensQ;
    // A saturated count exceeds quarterMax and so falls through to invalid.
    assign value = (cnt >= D_MIN && cnt <= D_MAX) ? 3'd2 :
                   (cnt >= N_MIN && cnt <= N_MAX) ? 3'd1 :
                   (cnt >= Q_MIN && cnt <= Q_MAX) ? 3'd5 : 3'd0;
    assign valid  = value != 3'd0;
    assign accept = state == IDLE && coin_ev && valid;
    // One spare bit keeps credit+value from wrapping before the price compare.
    assign sum = {1'b0, credit} + (CREDIT_W+1)'(value);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sensQ      <= 1'b0;
            retQ       <= 1'b0;
            sensPrev   <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
            credit     <= '0;
            dispense   <= 1'b0;
            coinReject <= 1'b0;
        end else begin
            sensQ      <= coinSensor;
            retQ       <= coinReturn;
            sensPrev   <= sensQ;
            cnt        <= sensQ ? (&cnt ? cnt : cnt + 1'b1) : '0;
            state      <= state_n;
            credit     <= credit_n;
            dispense   <= dispense_n;
            coinReject <= reject_n;
        end
    end

    // A coin event in IDLE takes priority; a held return request is seen again next cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (!coin_ev && retQ && credit != '0) ? RET_HI : IDLE;
            RET_HI:  state_n = RET_LO;
            RET_LO:  state_n = (credit != '0) ? RET_HI : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dispense_n   = accept && sum >= PRICE_W;
        reject_n     = coin_ev && (state != IDLE || !valid);
        credit_n     = state == RET_HI ? credit - 1'b1 :
                       dispense_n      ? CREDIT_W'(sum - PRICE_W) :
                       accept          ? sum[CREDIT_W-1:0] : credit;
        changeNickel = state == RET_HI;
        returning    = state != IDLE;
    end
endmodule
